// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the data-memory stage.
//   - RISC-V funct3 access-size encodings for loads and stores
//   - FSM state enum used by data_mem_ctrl (also exported on state_dbg)
//   - align_mask(): low-address bits that must be zero for a given size
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
  localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
  localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
  localparam logic [2:0] F3_D  = 3'b011;  // LD / SD
  localparam logic [2:0] F3_BU = 3'b100;  // LBU
  localparam logic [2:0] F3_HU = 3'b101;  // LHU
  localparam logic [2:0] F3_WU = 3'b110;  // LWU
  localparam logic [2:0] F3_XX = 3'b111;  // no such access

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  // size is funct3[1:0]: 0=byte, 1=half, 2=word, 3=double
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    logic [2:0] m;
    case (size)
      2'd0:    m = 3'b000;
      2'd1:    m = 3'b001;
      2'd2:    m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: request/response bundle between the pipeline and the
// data-memory stage.
//   master : execute-side driver (req_* / addr / wdata / sideband in)
//   slave  : data_mem_ctrl (ready, response, sideband out, stall, state_dbg)
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both 1. The master holds all request fields stable while
// req_valid=1 and req_ready=0. resp_valid is a single-cycle pulse with no
// back-pressure; rdata/fault/sideband outputs are meaningful while it is 1.
interface data_mem_ctrl_if #(
  parameter int XLEN = 64
);
  import mem_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic            mem_read;
  logic            mem_write;
  logic [2:0]      funct3;
  logic [4:0]      rd_in;
  logic            mem_to_reg_in;
  logic            reg_write_in;

  logic            resp_valid;
  logic [XLEN-1:0] rdata;
  logic [XLEN-1:0] alu_result_out;
  logic [4:0]      rd_out;
  logic            mem_to_reg_out;
  logic            reg_write_out;
  logic            fault;
  logic            stall;
  mem_state_e      state_dbg;

  modport master (
    output req_valid, addr, wdata, mem_read, mem_write, funct3,
           rd_in, mem_to_reg_in, reg_write_in,
    input  req_ready, resp_valid, rdata, alu_result_out, rd_out,
           mem_to_reg_out, reg_write_out, fault, stall, state_dbg
  );

  modport slave (
    input  req_valid, addr, wdata, mem_read, mem_write, funct3,
           rd_in, mem_to_reg_in, reg_write_in,
    output req_ready, resp_valid, rdata, alu_result_out, rd_out,
           mem_to_reg_out, reg_write_out, fault, stall, state_dbg
  );

endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering for the data memory.
//   byte_off  in  : addr low bits inside the XLEN word
//   funct3    in  : access size / sign
//   wdata     in  : LSB-aligned store data
//   rword     in  : full word read from the array
//   byte_en   out : store byte-enable mask, shifted to the addressed lane
//   wdata_sh  out : store data shifted to the addressed lane
//   load_data out : addressed lane, sign- or zero-extended to XLEN
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [$clog2(XLEN/8)-1:0] byte_off,
  input  logic [2:0]                funct3,
  input  logic [XLEN-1:0]           wdata,
  input  logic [XLEN-1:0]           rword,
  output logic [XLEN/8-1:0]         byte_en,
  output logic [XLEN-1:0]           wdata_sh,
  output logic [XLEN-1:0]           load_data
);

  localparam int BE_W     = XLEN / 8;
  localparam int ADDR_LSB = $clog2(BE_W);

  logic [ADDR_LSB+2:0] bit_off;
  logic [XLEN-1:0]     lane;
  logic [BE_W-1:0]     size_be;
  logic                fill;

  assign bit_off  = {byte_off, 3'b000};
  assign wdata_sh = wdata << bit_off;
  assign lane     = rword >> bit_off;
  assign byte_en  = size_be << byte_off;

  always_comb begin
    size_be = '1;
    case (funct3[1:0])
      2'd0:    size_be = BE_W'(1'b1);
      2'd1:    size_be = BE_W'(2'b11);
      2'd2:    size_be = BE_W'(4'hF);
      default: size_be = '1;
    endcase
  end

  // Fill the whole word with the extension bit, then overlay the lane.
  // This avoids zero-width replications when XLEN=32 and size=word.
  always_comb begin
    fill      = 1'b0;
    load_data = lane;
    case (funct3[1:0])
      2'd0: begin
        fill           = ~funct3[2] & lane[7];
        load_data      = {XLEN{fill}};
        load_data[7:0] = lane[7:0];
      end
      2'd1: begin
        fill            = ~funct3[2] & lane[15];
        load_data       = {XLEN{fill}};
        load_data[15:0] = lane[15:0];
      end
      2'd2: begin
        fill            = ~funct3[2] & lane[31];
        load_data       = {XLEN{fill}};
        load_data[31:0] = lane[31:0];
      end
      default: load_data = lane;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: data-memory pipeline stage with wait states.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   bus        : data_mem_ctrl_if.slave (request, response, sideband,
//                stall, state_dbg)
//   load_cnt / store_cnt / fault_cnt : saturating 32-bit completion
//                counters, present only when MEM_PERF_CNT_EN is defined
//
// Flow: IDLE/RESP accept a request. Memory ops go to BUSY for WAIT_STATES
// cycles (or straight to RESP when WAIT_STATES=0); non-memory ops pass
// straight to RESP. The array is read/written on the edge entering RESP,
// using the live request when entering from IDLE/RESP and the latched one
// when entering from BUSY.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic             clk,
  input  logic             reset,
  data_mem_ctrl_if.slave   bus
`ifdef MEM_PERF_CNT_EN
  ,
  output logic [31:0]      load_cnt,
  output logic [31:0]      store_cnt,
  output logic [31:0]      fault_cnt
`endif
);

  localparam int NBYTES   = XLEN / 8;
  localparam int ADDR_LSB = $clog2(NBYTES);
  localparam int IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  mem_state_e state, next_state;
  logic [3:0] wait_cnt;
  logic       accept;
  logic       commit;

  // latched request, consumed while in BUSY
  logic [XLEN-1:0] lat_addr, lat_wdata;
  logic [2:0]      lat_f3;
  logic            lat_read, lat_write;
  logic [4:0]      lat_rd;
  logic            lat_mtr, lat_rw;

  // request currently being committed
  logic [XLEN-1:0] cur_addr, cur_wdata;
  logic [2:0]      cur_f3;
  logic            cur_read, cur_write;
  logic [4:0]      cur_rd;
  logic            cur_mtr, cur_rw;
  logic            cur_mem, cur_fault;

  logic [IDX_W-1:0]    word_idx;
  logic [XLEN-1:0]     rword;
  logic [NBYTES-1:0]   byte_en;
  logic [XLEN-1:0]     wdata_sh;
  logic [XLEN-1:0]     load_ext;
  logic                do_write;

  // response registers
  logic [XLEN-1:0] rdata_q, alu_q;
  logic [4:0]      rd_q;
  logic            mtr_q, rw_q, fault_q;

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  assign bus.req_ready = (state == IDLE) || (state == RESP);
  assign accept        = bus.req_valid && bus.req_ready;

  always_comb begin
    if (state == BUSY) begin
      cur_addr  = lat_addr;
      cur_wdata = lat_wdata;
      cur_f3    = lat_f3;
      cur_read  = lat_read;
      cur_write = lat_write;
      cur_rd    = lat_rd;
      cur_mtr   = lat_mtr;
      cur_rw    = lat_rw;
    end else begin
      cur_addr  = bus.addr;
      cur_wdata = bus.wdata;
      cur_f3    = bus.funct3;
      cur_read  = bus.mem_read;
      cur_write = bus.mem_write;
      cur_rd    = bus.rd_in;
      cur_mtr   = bus.mem_to_reg_in;
      cur_rw    = bus.reg_write_in;
    end
  end

  // ---------------- next-state ----------------
  always_comb begin
    next_state = state;
    commit     = 1'b0;
    case (state)
      IDLE, RESP: begin
        if (accept) begin
          if ((bus.mem_read || bus.mem_write) && (WAIT_STATES > 0)) begin
            next_state = BUSY;
          end else begin
            next_state = RESP;
            commit     = 1'b1;
          end
        end else if (state == RESP) begin
          next_state = IDLE;
        end
      end
      BUSY: begin
        if (wait_cnt == 4'd0) begin
          next_state = RESP;
          commit     = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // ---------------- access checks ----------------
  logic misaligned, out_of_range, bad_f3, store_unsigned, rv32_bad, both_ops;

  always_comb begin
    cur_mem        = cur_read | cur_write;
    misaligned     = |(cur_addr[2:0] & align_mask(cur_f3[1:0]));
    out_of_range   = |cur_addr[XLEN-1:IDX_W+ADDR_LSB];
    bad_f3         = (cur_f3 == F3_XX);
    store_unsigned = cur_write & cur_f3[2];
    rv32_bad       = (XLEN == 32) && ((cur_f3 == F3_D) || (cur_f3 == F3_WU));
    both_ops       = cur_read & cur_write;
    cur_fault      = cur_mem & (misaligned | out_of_range | bad_f3 |
                                store_unsigned | rv32_bad | both_ops);
  end

  assign word_idx = cur_addr[IDX_W+ADDR_LSB-1:ADDR_LSB];
  assign rword    = mem[word_idx];

  mem_lane_align #(.XLEN(XLEN)) u_lane (
    .byte_off  (cur_addr[ADDR_LSB-1:0]),
    .funct3    (cur_f3),
    .wdata     (cur_wdata),
    .rword     (rword),
    .byte_en   (byte_en),
    .wdata_sh  (wdata_sh),
    .load_data (load_ext)
  );

  // A clock edge seen while reset is high must never commit a store.
  assign do_write = commit & cur_write & ~cur_fault & ~reset;

  // Array has no reset; contents are undefined after power-up.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (byte_en[i]) mem[word_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  // ---------------- state and response registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_f3    <= 3'd0;
      lat_read  <= 1'b0;
      lat_write <= 1'b0;
      lat_rd    <= 5'd0;
      lat_mtr   <= 1'b0;
      lat_rw    <= 1'b0;
      rdata_q   <= '0;
      alu_q     <= '0;
      rd_q      <= 5'd0;
      mtr_q     <= 1'b0;
      rw_q      <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        lat_addr  <= bus.addr;
        lat_wdata <= bus.wdata;
        lat_f3    <= bus.funct3;
        lat_read  <= bus.mem_read;
        lat_write <= bus.mem_write;
        lat_rd    <= bus.rd_in;
        lat_mtr   <= bus.mem_to_reg_in;
        lat_rw    <= bus.reg_write_in;
      end
      if (accept && (next_state == BUSY)) begin
        wait_cnt <= WS_LOAD;
      end else if ((state == BUSY) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (commit) begin
        alu_q   <= cur_addr;
        rd_q    <= cur_rd;
        mtr_q   <= cur_mtr;
        rw_q    <= cur_rw & ~cur_fault;
        fault_q <= cur_fault;
        rdata_q <= (cur_read && !cur_fault) ? load_ext : '0;
      end
    end
  end

  assign bus.resp_valid     = (state == RESP);
  assign bus.fault          = fault_q & (state == RESP);
  assign bus.rdata          = rdata_q;
  assign bus.alu_result_out = alu_q;
  assign bus.rd_out         = rd_q;
  assign bus.mem_to_reg_out = mtr_q;
  assign bus.reg_write_out  = rw_q;
  assign bus.stall          = (state == BUSY) || (bus.req_valid && !bus.req_ready);
  assign bus.state_dbg      = state;

`ifdef MEM_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_cnt  <= 32'd0;
      store_cnt <= 32'd0;
      fault_cnt <= 32'd0;
    end else if (commit && cur_mem) begin
      if (cur_fault) begin
        if (fault_cnt != 32'hFFFF_FFFF) fault_cnt <= fault_cnt + 32'd1;
      end else if (cur_read) begin
        if (load_cnt != 32'hFFFF_FFFF) load_cnt <= load_cnt + 32'd1;
      end else begin
        if (store_cnt != 32'hFFFF_FFFF) store_cnt <= store_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed bench for data_mem_ctrl.
//   dut0: XLEN=64, DEPTH_WORDS=1024, WAIT_STATES=0 (sizes, extension, faults)
//   dut1: XLEN=64, DEPTH_WORDS=64,   WAIT_STATES=3 (stall, back-to-back, reset)
// Counter checks are compiled in when MEM_PERF_CNT_EN is defined.
module tb_data_mem_ctrl;
  import mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;
  int checks = 0;
  int errors = 0;
  int lat;

  data_mem_ctrl_if #(.XLEN(64)) b0 ();
  data_mem_ctrl_if #(.XLEN(64)) b1 ();

`ifdef MEM_PERF_CNT_EN
  logic [31:0] lc0, sc0, fc0, lc1, sc1, fc1;
`endif

  data_mem_ctrl #(.XLEN(64), .DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(rst0), .bus(b0.slave)
`ifdef MEM_PERF_CNT_EN
    , .load_cnt(lc0), .store_cnt(sc0), .fault_cnt(fc0)
`endif
  );

  data_mem_ctrl #(.XLEN(64), .DEPTH_WORDS(64), .WAIT_STATES(3)) dut1 (
    .clk(clk), .reset(rst1), .bus(b1.slave)
`ifdef MEM_PERF_CNT_EN
    , .load_cnt(lc1), .store_cnt(sc1), .fault_cnt(fc1)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic rd_, input logic wr_,
                       input logic [2:0] f3, input logic [63:0] a, input logic [63:0] d,
                       input logic [4:0] rdr, input logic rw);
    if (sel == 0) begin
      b0.req_valid = v; b0.mem_read = rd_; b0.mem_write = wr_; b0.funct3 = f3;
      b0.addr = a; b0.wdata = d; b0.rd_in = rdr; b0.mem_to_reg_in = rd_;
      b0.reg_write_in = rw;
    end else begin
      b1.req_valid = v; b1.mem_read = rd_; b1.mem_write = wr_; b1.funct3 = f3;
      b1.addr = a; b1.wdata = d; b1.rd_in = rdr; b1.mem_to_reg_in = rd_;
      b1.reg_write_in = rw;
    end
  endtask

  // dut0: one request, returns 1ns after the negedge of the expected RESP cycle
  task automatic op0(input logic rd_, input logic wr_, input logic [2:0] f3,
                     input logic [63:0] a, input logic [63:0] d,
                     input logic [4:0] rdr, input logic rw);
    @(negedge clk);
    drive(0, 1'b1, rd_, wr_, f3, a, d, rdr, rw);
    @(negedge clk);
    b0.req_valid = 1'b0;
    #1;
  endtask

  // dut1: one request, waits (bounded) for resp_valid; lat counts cycles after accept
  task automatic op1(input logic rd_, input logic wr_, input logic [2:0] f3,
                     input logic [63:0] a, input logic [63:0] d,
                     input logic [4:0] rdr, input logic rw, output int l);
    @(negedge clk);
    drive(1, 1'b1, rd_, wr_, f3, a, d, rdr, rw);
    @(negedge clk);
    b1.req_valid = 1'b0;
    #1;
    l = 1;
    while (!b1.resp_valid && l < 12) begin
      @(negedge clk);
      #1;
      l++;
    end
  endtask

  task automatic resp0(input string tag, input logic [63:0] rdata, input logic flt,
                       input logic rw);
    chk({tag, ".valid"}, 64'(b0.resp_valid), 64'd1);
    chk({tag, ".rdata"}, b0.rdata, rdata);
    chk({tag, ".fault"}, 64'(b0.fault), 64'(flt));
    chk({tag, ".rw"},    64'(b0.reg_write_out), 64'(rw));
  endtask

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b0);
    @(negedge clk);
    #1;
    chk("rst.ready", 64'(b0.req_ready), 64'd1);
    chk("rst.resp",  64'(b0.resp_valid), 64'd0);
    chk("rst.stall", 64'(b0.stall), 64'd0);
    chk("rst.fault", 64'(b0.fault), 64'd0);
    chk("rst.rdata", b0.rdata, 64'd0);
    chk("rst.alu",   b0.alu_result_out, 64'd0);
    chk("rst.rd",    64'(b0.rd_out), 64'd0);
    chk("rst.mtr",   64'(b0.mem_to_reg_out), 64'd0);
    chk("rst.rw",    64'(b0.reg_write_out), 64'd0);
    chk("rst.state", 64'(b1.state_dbg), 64'(IDLE));
    @(negedge clk);
    rst0 = 1'b0;
    rst1 = 1'b0;

    // ---- dut0: sizes and extension ----
    op0(1'b0, 1'b1, F3_D, 64'h10, 64'h1122334455667788, 5'd0, 1'b0);
    resp0("sd10", 64'd0, 1'b0, 1'b0);
    op0(1'b1, 1'b0, F3_D, 64'h10, 64'd0, 5'd5, 1'b1);
    resp0("ld10", 64'h1122334455667788, 1'b0, 1'b1);
    chk("ld10.rd",  64'(b0.rd_out), 64'd5);
    chk("ld10.alu", b0.alu_result_out, 64'h10);
    chk("ld10.mtr", 64'(b0.mem_to_reg_out), 64'd1);

    op0(1'b0, 1'b1, F3_B, 64'h13, 64'h12345680, 5'd0, 1'b0);
    resp0("sb13", 64'd0, 1'b0, 1'b0);
    op0(1'b1, 1'b0, F3_B, 64'h13, 64'd0, 5'd1, 1'b1);
    resp0("lb13", 64'hFFFFFFFFFFFFFF80, 1'b0, 1'b1);
    op0(1'b1, 1'b0, F3_BU, 64'h13, 64'd0, 5'd1, 1'b1);
    resp0("lbu13", 64'h80, 1'b0, 1'b1);
    op0(1'b1, 1'b0, F3_D, 64'h10, 64'd0, 5'd1, 1'b1);
    resp0("ld10b", 64'h1122334480667788, 1'b0, 1'b1);
    op0(1'b1, 1'b0, F3_H, 64'h16, 64'd0, 5'd1, 1'b1);
    resp0("lh16", 64'h1122, 1'b0, 1'b1);
    op0(1'b1, 1'b0, F3_HU, 64'h14, 64'd0, 5'd1, 1'b1);
    resp0("lhu14", 64'h3344, 1'b0, 1'b1);
    op0(1'b1, 1'b0, F3_W, 64'h14, 64'd0, 5'd1, 1'b1);
    resp0("lw14", 64'h11223344, 1'b0, 1'b1);
    op0(1'b1, 1'b0, F3_W, 64'h10, 64'd0, 5'd1, 1'b1);
    resp0("lw10", 64'hFFFFFFFF80667788, 1'b0, 1'b1);
    op0(1'b1, 1'b0, F3_WU, 64'h10, 64'd0, 5'd1, 1'b1);
    resp0("lwu10", 64'h80667788, 1'b0, 1'b1);
    op0(1'b0, 1'b1, F3_H, 64'h16, 64'hFFFFBEEF, 5'd0, 1'b0);
    resp0("sh16", 64'd0, 1'b0, 1'b0);
    op0(1'b1, 1'b0, F3_H, 64'h16, 64'd0, 5'd1, 1'b1);
    resp0("lh16b", 64'hFFFFFFFFFFFFBEEF, 1'b0, 1'b1);

    // ---- dut0: faults ----
    op0(1'b1, 1'b0, F3_W, 64'h12, 64'd0, 5'd2, 1'b1);
    resp0("lw12", 64'd0, 1'b1, 1'b0);
    op0(1'b1, 1'b0, F3_H, 64'h11, 64'd0, 5'd2, 1'b1);
    resp0("lh11", 64'd0, 1'b1, 1'b0);
    op0(1'b1, 1'b0, F3_D, 64'h2000, 64'd0, 5'd2, 1'b1);
    resp0("ld2000", 64'd0, 1'b1, 1'b0);
    op0(1'b1, 1'b0, F3_XX, 64'h10, 64'd0, 5'd2, 1'b1);
    resp0("f3_111", 64'd0, 1'b1, 1'b0);
    op0(1'b0, 1'b1, F3_W, 64'h12, 64'hFFFFFFFF, 5'd2, 1'b1);
    resp0("sw12", 64'd0, 1'b1, 1'b0);
    op0(1'b0, 1'b1, F3_BU, 64'h10, 64'd0, 5'd2, 1'b1);
    resp0("sbu10", 64'd0, 1'b1, 1'b0);
    op0(1'b1, 1'b1, F3_D, 64'h10, 64'd0, 5'd2, 1'b1);
    resp0("rdwr10", 64'd0, 1'b1, 1'b0);
    op0(1'b1, 1'b0, F3_D, 64'h10, 64'd0, 5'd1, 1'b1);
    resp0("ld10c", 64'hBEEF334480667788, 1'b0, 1'b1);

    // last in-range word
    op0(1'b0, 1'b1, F3_D, 64'h1FF8, 64'h0123456789ABCDEF, 5'd0, 1'b0);
    resp0("sd1ff8", 64'd0, 1'b0, 1'b0);
    op0(1'b1, 1'b0, F3_D, 64'h1FF8, 64'd0, 5'd1, 1'b1);
    resp0("ld1ff8", 64'h0123456789ABCDEF, 1'b0, 1'b1);

    // non-memory pass-through; funct3=111 is irrelevant here
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 1'b0, F3_XX, 64'hDEAD, 64'd0, 5'd7, 1'b1);
    @(negedge clk);
    b0.req_valid = 1'b0;
    #1;
    resp0("alu", 64'd0, 1'b0, 1'b1);
    chk("alu.res", b0.alu_result_out, 64'hDEAD);
    chk("alu.rd",  64'(b0.rd_out), 64'd7);
    chk("alu.mtr", 64'(b0.mem_to_reg_out), 64'd0);

    // store then load accepted in the store's RESP cycle
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 1'b1, F3_D, 64'h40, 64'hCAFEBABE0BADF00D, 5'd0, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 1'b0, F3_D, 64'h40, 64'd0, 5'd9, 1'b1);
    #1;
    chk("b2b0.sresp", 64'(b0.resp_valid), 64'd1);
    chk("b2b0.ready", 64'(b0.req_ready), 64'd1);
    @(negedge clk);
    b0.req_valid = 1'b0;
    #1;
    resp0("b2b0.ld", 64'hCAFEBABE0BADF00D, 1'b0, 1'b1);
    chk("b2b0.rd", 64'(b0.rd_out), 64'd9);

    // ---- dut1: wait states, back-to-back ----
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 1'b1, F3_D, 64'h8, 64'h0102030405060708, 5'd3, 1'b0);
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 1'b0, F3_D, 64'h8, 64'd0, 5'd4, 1'b1);
    #1;
    chk("ws.c1.stall", 64'(b1.stall), 64'd1);
    chk("ws.c1.ready", 64'(b1.req_ready), 64'd0);
    chk("ws.c1.resp",  64'(b1.resp_valid), 64'd0);
    chk("ws.c1.state", 64'(b1.state_dbg), 64'(BUSY));
    @(negedge clk);
    #1;
    chk("ws.c2.stall", 64'(b1.stall), 64'd1);
    @(negedge clk);
    #1;
    chk("ws.c3.stall", 64'(b1.stall), 64'd1);
    chk("ws.c3.resp",  64'(b1.resp_valid), 64'd0);
    @(negedge clk);
    #1;
    chk("ws.c4.resp",  64'(b1.resp_valid), 64'd1);
    chk("ws.c4.stall", 64'(b1.stall), 64'd0);
    chk("ws.c4.ready", 64'(b1.req_ready), 64'd1);
    chk("ws.c4.alu",   b1.alu_result_out, 64'h8);
    @(negedge clk);
    b1.req_valid = 1'b0;
    #1;
    chk("ws.ld.busy", 64'(b1.stall), 64'd1);
    lat = 1;
    while (!b1.resp_valid && lat < 12) begin
      @(negedge clk);
      #1;
      lat++;
    end
    chk("ws.ld.lat",   64'(lat), 64'd4);
    chk("ws.ld.rdata", b1.rdata, 64'h0102030405060708);
    chk("ws.ld.rd",    64'(b1.rd_out), 64'd4);

    // ---- dut1: reset while a store is in BUSY ----
    op1(1'b0, 1'b1, F3_D, 64'h20, 64'h5555, 5'd3, 1'b0, lat);
    chk("sd20.lat", 64'(lat), 64'd4);
    chk("sd20.alu", b1.alu_result_out, 64'h20);
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 1'b1, F3_D, 64'h20, 64'hAAAA, 5'd6, 1'b0);
    @(negedge clk);
    b1.req_valid = 1'b0;
    #1;
    chk("rstb.busy", 64'(b1.stall), 64'd1);
    #2;
    rst1 = 1'b1;
    #1;
    chk("rstb.state", 64'(b1.state_dbg), 64'(IDLE));
    chk("rstb.ready", 64'(b1.req_ready), 64'd1);
    chk("rstb.stall", 64'(b1.stall), 64'd0);
    chk("rstb.resp",  64'(b1.resp_valid), 64'd0);
    chk("rstb.alu",   b1.alu_result_out, 64'd0);
    chk("rstb.rd",    64'(b1.rd_out), 64'd0);
`ifdef MEM_PERF_CNT_EN
    chk("rstb.lcnt", 64'(lc1), 64'd0);
    chk("rstb.scnt", 64'(sc1), 64'd0);
    chk("rstb.fcnt", 64'(fc1), 64'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst1 = 1'b0;
    op1(1'b1, 1'b0, F3_D, 64'h20, 64'd0, 5'd1, 1'b1, lat);
    chk("dropped.lat",   64'(lat), 64'd4);
    chk("dropped.rdata", b1.rdata, 64'h5555);
    op1(1'b0, 1'b1, F3_D, 64'h20, 64'd0, 5'd0, 1'b0, lat);
    chk("sd20z.lat", 64'(lat), 64'd4);
    op1(1'b1, 1'b0, F3_D, 64'h20, 64'd0, 5'd1, 1'b1, lat);
    chk("ld20z.rdata", b1.rdata, 64'd0);
    op1(1'b1, 1'b0, F3_W, 64'h22, 64'd0, 5'd1, 1'b1, lat);
    chk("lw22.lat",   64'(lat), 64'd4);
    chk("lw22.fault", 64'(b1.fault), 64'd1);
    chk("lw22.rdata", b1.rdata, 64'd0);
    chk("lw22.rw",    64'(b1.reg_write_out), 64'd0);
`ifdef MEM_PERF_CNT_EN
    chk("cnt.load",  64'(lc1), 64'd2);
    chk("cnt.store", 64'(sc1), 64'd1);
    chk("cnt.fault", 64'(fc1), 64'd1);
`endif

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
